// File: rtl/cla_serial_adder_ctrl.sv
// Serial WIDTH-bit add/subtract unit: one 4-bit CLA reused per nibble, LSB first,
// carry chained through a register, with start/done handshake and ALU flags.
module cla_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] op_a, op_b, s_next;
    logic             carry;
    logic [3:0]       nib_a, nib_b, nib_s, g, p;
    logic [4:0]       c;
    logic             accept, last;

    assign ready  = (state == IDLE) || (state == DONE);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign accept = ready & start;
    assign last   = (idx == LAST_IDX);

    // Nibble CLA plus the result as it will look after this edge's write
    always_comb begin
        nib_a = op_a[{idx, 2'b00} +: 4];
        nib_b = op_b[{idx, 2'b00} +: 4];
        g     = nib_a & nib_b;
        p     = nib_a ^ nib_b;
        c[0]  = carry;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        nib_s = p ^ c[3:0];
        s_next = S;
        s_next[{idx, 2'b00} +: 4] = nib_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            carry    <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            S        <= '0;
            C_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            op_a     <= A;
            op_b     <= B ^ {WIDTH{sub}};
            carry    <= sub;
            idx      <= '0;
            S        <= '0;
            C_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (busy) begin
            S     <= s_next;
            carry <= c[4];
            if (last) begin
                idx      <= '0;
                C_out    <= c[4];
                overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) & (nib_s[3] != op_a[WIDTH-1]);
                zero     <= (s_next == '0);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Self-checking bench: directed literal cases plus random traffic against an
// arithmetic reference model compared on every falling edge.
module tb_cla_serial_adder_ctrl;

    localparam int NIB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic        ready, busy, done, C_out, overflow, zero;
    logic [31:0] S;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    cla_serial_adder_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
        .ready(ready), .busy(busy), .done(done), .S(S),
        .C_out(C_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: counts edges left in the operation, result from plain arithmetic
    int          run_left = 0;
    bit          m_done = 0;
    logic [31:0] m_S = '0, p_S = '0;
    bit          m_C = 0, m_V = 0, m_Z = 0, p_C = 0, p_V = 0;

    function automatic logic [31:0] low_mask(input int k);
        return 32'((64'd1 << (4 * k)) - 64'd1);
    endfunction

    always @(posedge clk or posedge rst) begin
        bit acc, fin;
        longint ra, rb, r;
        if (rst) begin
            run_left = 0; m_done = 0; m_S = '0; m_C = 0; m_V = 0; m_Z = 0;
        end else begin
            acc = (run_left == 0) && start;
            fin = (run_left == 1);
            if (run_left > 0) begin
                run_left--;
                m_S = p_S & low_mask(NIB - run_left);
            end
            if (fin) begin
                m_C = p_C; m_V = p_V; m_Z = (p_S == 0);
            end
            if (acc) begin
                ra = longint'($signed(A));
                rb = longint'($signed(B));
                r  = sub ? ra - rb : ra + rb;
                p_S = r[31:0];
                p_V = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                p_C = sub ? (A >= B) : (((64'(A) + 64'(B)) >> 32) != 0);
                run_left = NIB;
                m_S = '0; m_C = 0; m_V = 0; m_Z = 0;
            end
            m_done = fin;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(ready), 32'(run_left == 0));
            chk("busy", 32'(busy), 32'(run_left > 0));
            chk("done", 32'(done), 32'(m_done));
            chk("S", S, m_S);
            chk("C_out", 32'(C_out), 32'(m_C));
            chk("overflow", 32'(overflow), 32'(m_V));
            chk("zero", 32'(zero), 32'(m_Z));
        end
    end

    // Called right after the accept edge; counts clocks until done appears
    task automatic wait_done(input logic [31:0] eS, input logic eC, eV, eZ,
                             input int inj, input bit b2b, input string nm);
        int cyc = 0;
        bit seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (inj != 0 && cyc == inj) begin
                start = 1; A = 32'd1; B = 32'd1; sub = 0;
            end else if (inj != 0 && cyc == inj + 1) begin
                start = 0;
            end
            if (done) seen = 1;
        end
        chk({nm, "_latency"}, 32'(cyc - 1), 32'(NIB));
        chk({nm, "_S"}, S, eS);
        chk({nm, "_C"}, 32'(C_out), 32'(eC));
        chk({nm, "_V"}, 32'(overflow), 32'(eV));
        chk({nm, "_Z"}, 32'(zero), 32'(eZ));
        if (b2b) begin
            start = 1; A = 32'd10; B = 32'd20; sub = 0;
        end
    endtask

    task automatic issue(input logic [31:0] a, b, input logic s);
        int w = 0;
        @(posedge clk); #1;
        while (!ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        A = a; B = b; sub = s; start = 1;
        @(posedge clk); #1;
        start = 0; A = $urandom; B = $urandom; sub = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic [31:0] a, b, input logic s, input logic [31:0] eS,
                          input logic eC, eV, eZ, input int inj, input bit b2b, input string nm);
        issue(a, b, s);
        wait_done(eS, eC, eV, eZ, inj, b2b, nm);
    endtask

    logic [31:0] corner [4];

    initial begin
        corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;

        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_S", S, 32'd0);

        run_op(32'h0000_000F, 32'h0000_0001, 0, 32'h0000_0010, 0, 0, 0, 0, 0, "t1");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 0, 1, 0, 0, 0, "t2a");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1, 0, 1, 0, 0, "t2b");
        run_op(32'd5, 32'd7, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, "t3a");
        run_op(32'd7, 32'd5, 1, 32'h0000_0002, 1, 0, 0, 0, 0, "t3b");
        run_op(32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 1, 1, 0, 0, 0, "t3c");
        run_op(32'h1234_5678, 32'h1111_1111, 0, 32'h2345_6789, 0, 0, 0, 3, 0, "t4");

        // Asynchronous reset in the middle of a running operation
        issue(32'h1234_5678, 32'h1111_1111, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("t5_ready", 32'(ready), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_S", S, 32'd0);
        chk("t5_flags", {29'd0, C_out, overflow, zero}, 32'd0);
        @(posedge clk); #1 rst = 0;
        run_op(32'd2, 32'd3, 0, 32'd5, 0, 0, 0, 0, 0, "t5b");

        run_op(32'd1, 32'd2, 0, 32'd3, 0, 0, 0, 0, 1, "t6a");
        @(posedge clk); #1;
        start = 0;
        chk("t6_no_idle", 32'(busy), 32'd1);
        wait_done(32'd30, 0, 0, 0, 0, 0, "t6b");

        // Random traffic, including back-to-back starts, ignored starts and resets
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 3) == 0);
            A     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            B     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            sub   = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        rst = 0; start = 0;
        repeat (12) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
